ekf_stage_sched: RTL and testbench

- Parametrised successor to the single-request RSA stage front end.
- Queues one-hot EKF stage requests (predict / new-landmark / update, extensible to STAGE_NUM stages) in a small FIFO, issues them one at a time to the RSA datapath as init pulses, and waits for the matching done.
- On done, writes the result bus back into the robot/landmark state registers through a per-stage map.
- Adds a watchdog timeout, an l_k range check and sticky error flags.

---
 rtl/ekf_stage_sched_pkg.sv | 23 ++
 rtl/ekf_stage_sched_if.sv | 40 ++++
 rtl/ekf_stage_sched_fifo.sv | 51 +++++
 rtl/ekf_stage_sched.sv | 166 ++++++++++++++++
 tb/tb_ekf_stage_sched.sv | 368 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ekf_stage_sched_pkg.sv
// Shared definitions for the EKF stage scheduler: FSM encodings, stage bit
// positions and the result-word indices used by the writeback map.
package ekf_stage_pkg;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE  = 2'd0;
    localparam state_t S_ISSUE = 2'd1;
    localparam state_t S_WAIT  = 2'd2;
    localparam state_t S_WB    = 2'd3;

    localparam int unsigned PRD = 0;
    localparam int unsigned NEW = 1;
    localparam int unsigned UPD = 2;

    localparam int unsigned R0 = 0;
    localparam int unsigned R1 = 1;
    localparam int unsigned R2 = 2;
    localparam int unsigned R3 = 3;
    localparam int unsigned R4 = 4;
    localparam int unsigned R5 = 5;

endpackage

// File: rtl/ekf_stage_sched_if.sv
// Request, RSA handshake and state-register bundle of the EKF stage scheduler.
// The master modport is the client/datapath side, slave is the scheduler.
interface ekf_stage_sched_if #(
    parameter int unsigned RSA_DW    = 16,
    parameter int unsigned ROW_LEN   = 10,
    parameter int unsigned STAGE_NUM = 3,
    parameter int unsigned RES_NUM   = 6
);
    logic [STAGE_NUM-1:0]      stage_val;
    logic [STAGE_NUM-1:0]      stage_rdy;
    logic [ROW_LEN-1:0]        landmark_num;
    logic [ROW_LEN-1:0]        l_k;
    logic [STAGE_NUM-1:0]      init;
    logic [STAGE_NUM-1:0]      done;
    logic [RES_NUM*RSA_DW-1:0] result;
    logic [RSA_DW-1:0]         xk;
    logic [RSA_DW-1:0]         yk;
    logic [RSA_DW-1:0]         xita;
    logic [RSA_DW-1:0]         lkx;
    logic [RSA_DW-1:0]         lky;
    logic [ROW_LEN-1:0]        cur_lk;
    logic                      busy;
    logic                      err_tmo;
    logic                      err_req;
    logic                      err_lk;
    logic                      err_clr;

    modport master (
        output stage_val, landmark_num, l_k, done, result, err_clr,
        input  stage_rdy, init, xk, yk, xita, lkx, lky, cur_lk, busy,
               err_tmo, err_req, err_lk
    );

    modport slave (
        input  stage_val, landmark_num, l_k, done, result, err_clr,
        output stage_rdy, init, xk, yk, xita, lkx, lky, cur_lk, busy,
               err_tmo, err_req, err_lk
    );

endinterface

// File: rtl/ekf_stage_sched_fifo.sv
// Request FIFO for the stage scheduler; pointers carry one extra MSB so that
// full and empty are told apart without a separate occupancy counter.
module stage_req_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 13
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             wr_en;
    logic             rd_en;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rdata = mem[rd_ptr[AW-1:0]];
    assign wr_en = push && !full;
    assign rd_en = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    // Storage is not reset; the pointer reset alone flushes the queue.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/ekf_stage_sched.sv
// EKF stage scheduler: queues one-hot stage requests, issues them to the RSA
// datapath one at a time and writes results back into the state registers.
module ekf_stage_sched #(
    parameter int unsigned RSA_DW    = 16,
    parameter int unsigned ROW_LEN   = 10,
    parameter int unsigned STAGE_NUM = 3,
    parameter int unsigned RES_NUM   = 6,
    parameter int unsigned QDEPTH    = 4,
    parameter int unsigned TMO_W     = 12
) (
    input logic              clk,
    input logic              sys_rst_n,
    ekf_stage_sched_if.slave bus
);
    import ekf_stage_pkg::*;

    localparam int unsigned EW = STAGE_NUM + ROW_LEN;

    state_t                    state;
    logic [STAGE_NUM-1:0]      cur_stage;
    logic [ROW_LEN-1:0]        cur_lk_q;
    logic [TMO_W-1:0]          wd;
    logic [RES_NUM*RSA_DW-1:0] shadow;
    logic [RSA_DW-1:0]         xk_q;
    logic [RSA_DW-1:0]         yk_q;
    logic [RSA_DW-1:0]         xita_q;
    logic [RSA_DW-1:0]         lkx_q;
    logic [RSA_DW-1:0]         lky_q;
    logic                      err_tmo_q;
    logic                      err_req_q;
    logic                      err_lk_q;

    logic                      full;
    logic                      empty;
    logic                      push;
    logic                      pop;
    logic [EW-1:0]             head;
    logic                      req_one_hot;
    logic                      req_bad;
    logic                      lk_bad;
    logic                      issue_ok;
    logic                      done_hit;
    logic                      tmo_hit;

    function automatic logic [RSA_DW-1:0] rword(input int unsigned idx);
        return shadow[idx*RSA_DW +: RSA_DW];
    endfunction

    always_comb begin
        req_one_hot = $onehot(bus.stage_val);
        push        = req_one_hot && !full;
        req_bad     = (|bus.stage_val) && (!req_one_hot || full);
        pop         = (state == S_IDLE) && !empty;
        lk_bad      = (state == S_ISSUE) && cur_stage[UPD] && (cur_lk_q >= bus.landmark_num);
        issue_ok    = (state == S_ISSUE) && !lk_bad;
        done_hit    = (state == S_WAIT) && (|(bus.done & cur_stage));
        // done in the terminal-count cycle takes priority over the timeout
        tmo_hit     = (state == S_WAIT) && !done_hit && (wd == '1);
    end

    stage_req_fifo #(
        .DEPTH (QDEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (sys_rst_n),
        .push  (push),
        .pop   (pop),
        .wdata ({bus.stage_val, bus.l_k}),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= S_IDLE;
            cur_stage <= '0;
            cur_lk_q  <= '0;
            wd        <= '0;
            shadow    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        {cur_stage, cur_lk_q} <= head;
                        state                 <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    wd    <= '0;
                    state <= lk_bad ? S_IDLE : S_WAIT;
                end
                S_WAIT: begin
                    if (done_hit) begin
                        shadow <= bus.result;
                        state  <= S_WB;
                    end else if (tmo_hit) begin
                        state <= S_IDLE;
                    end else begin
                        wd <= wd + TMO_W'(1);
                    end
                end
                S_WB: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Writeback map; stages above UPD have no destination registers.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            xk_q   <= '0;
            yk_q   <= '0;
            xita_q <= '0;
            lkx_q  <= '0;
            lky_q  <= '0;
        end else if (state == S_WB) begin
            if (cur_stage[PRD]) begin
                xk_q   <= rword(R1);
                yk_q   <= rword(R2);
                xita_q <= rword(R3);
            end else if (cur_stage[NEW]) begin
                lkx_q <= rword(R0) + rword(R1);
                lky_q <= rword(R2) + rword(R3);
            end else if (cur_stage[UPD]) begin
                xk_q   <= rword(R1);
                yk_q   <= rword(R2);
                xita_q <= rword(R3);
                lkx_q  <= rword(R4);
                lky_q  <= rword(R5);
            end
        end
    end

    // A new error event in the clear cycle keeps its flag set.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            err_tmo_q <= 1'b0;
            err_req_q <= 1'b0;
            err_lk_q  <= 1'b0;
        end else begin
            err_tmo_q <= (err_tmo_q && !bus.err_clr) || tmo_hit;
            err_req_q <= (err_req_q && !bus.err_clr) || req_bad;
            err_lk_q  <= (err_lk_q && !bus.err_clr) || lk_bad;
        end
    end

    assign bus.stage_rdy = full ? '0 : '1;
    assign bus.init      = issue_ok ? cur_stage : '0;
    assign bus.cur_lk    = cur_lk_q;
    assign bus.busy      = (state != S_IDLE) || !empty;
    assign bus.xk        = xk_q;
    assign bus.yk        = yk_q;
    assign bus.xita      = xita_q;
    assign bus.lkx       = lkx_q;
    assign bus.lky       = lky_q;
    assign bus.err_tmo   = err_tmo_q;
    assign bus.err_req   = err_req_q;
    assign bus.err_lk    = err_lk_q;

endmodule

// File: tb/tb_ekf_stage_sched.sv
// Scoreboard bench for ekf_stage_sched: directed scenarios plus a randomized
// phase, with a responder standing in for the RSA datapath.
`timescale 1ns/1ps
module tb_ekf_stage_sched;
    localparam int unsigned DW = 16;
    localparam int unsigned RL = 10;
    localparam int unsigned SN = 3;
    localparam int unsigned RN = 6;
    localparam int unsigned QD = 4;
    localparam int unsigned TW = 6;
    localparam int TMO_CYC = 1 << TW;

    typedef struct {
        logic [SN-1:0] stage;
        logic [RL-1:0] lk;
        int            exp_cyc;
    } iss_t;

    typedef struct {
        int            due;
        logic [DW-1:0] xk, yk, xita, lkx, lky;
    } wb_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ekf_stage_sched_if #(.RSA_DW(DW), .ROW_LEN(RL), .STAGE_NUM(SN), .RES_NUM(RN)) bus ();

    ekf_stage_sched #(
        .RSA_DW(DW), .ROW_LEN(RL), .STAGE_NUM(SN), .RES_NUM(RN), .QDEPTH(QD), .TMO_W(TW)
    ) dut (
        .clk       (clk),
        .sys_rst_n (rst_n),
        .bus       (bus)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    iss_t             exp_iss[$];
    wb_t              exp_wb[$];
    int               lat_q[$];
    logic [RN*DW-1:0] res_q[$];
    logic [DW-1:0]    m_xk = '0, m_yk = '0, m_xita = '0, m_lkx = '0, m_lky = '0;
    logic [RL-1:0]    m_lmn = '0;
    bit               m_err_lk = 0, m_err_req = 0;
    int               inits_seen = 0, last_init_cyc = -1, last_done_cyc = -1, busy_fall_cyc = -1;
    bit               prev_busy = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [RN*DW-1:0] rand_res();
        logic [RN*DW-1:0] r;
        for (int i = 0; i < RN; i++) r[i*DW +: DW] = DW'($urandom);
        return r;
    endfunction

    // Reference writeback: words of the result bus mapped per stage.
    task automatic model_wb(input logic [SN-1:0] st, input logic [RN*DW-1:0] res, input int due);
        logic [DW-1:0] r [RN];
        wb_t w;
        for (int i = 0; i < RN; i++) r[i] = res[i*DW +: DW];
        case (st)
            3'b001: begin m_xk = r[1]; m_yk = r[2]; m_xita = r[3]; end
            3'b010: begin m_lkx = DW'(r[0] + r[1]); m_lky = DW'(r[2] + r[3]); end
            3'b100: begin m_xk = r[1]; m_yk = r[2]; m_xita = r[3]; m_lkx = r[4]; m_lky = r[5]; end
            default: ;
        endcase
        w.due = due; w.xk = m_xk; w.yk = m_yk; w.xita = m_xita; w.lkx = m_lkx; w.lky = m_lky;
        exp_wb.push_back(w);
    endtask

    // Monitor: compares every init pulse and every scheduled writeback.
    always @(negedge clk) begin
        iss_t e;
        wb_t  w;
        if (rst_n) begin
            if (bus.init != '0) begin
                inits_seen++;
                last_init_cyc = cyc;
                if (exp_iss.size() == 0) begin
                    chk("unexpected_init", bus.init, 0);
                end else begin
                    e = exp_iss.pop_front();
                    chk("init_stage", bus.init, e.stage);
                    chk("init_cur_lk", bus.cur_lk, e.lk);
                    if (e.exp_cyc >= 0) chk("init_latency", cyc, e.exp_cyc);
                end
            end
            if (exp_wb.size() != 0 && exp_wb[0].due == cyc) begin
                w = exp_wb.pop_front();
                chk("wb_xk", bus.xk, w.xk);
                chk("wb_yk", bus.yk, w.yk);
                chk("wb_xita", bus.xita, w.xita);
                chk("wb_lkx", bus.lkx, w.lkx);
                chk("wb_lky", bus.lky, w.lky);
            end
            if (prev_busy && !bus.busy) busy_fall_cyc = cyc;
            prev_busy = bus.busy;
        end else begin
            prev_busy = 0;
        end
    end

    // Responder: answers each init with done after a chosen latency (-1 = never).
    initial begin
        logic [SN-1:0]    st;
        logic [RN*DW-1:0] res;
        int               lat;
        bus.done   = '0;
        bus.result = '0;
        forever begin
            @(negedge clk);
            if (rst_n && bus.init != '0) begin
                st  = bus.init;
                lat = (lat_q.size() != 0) ? lat_q.pop_front() : int'($urandom_range(0, 6));
                res = (res_q.size() != 0) ? res_q.pop_front() : rand_res();
                if (lat >= 0) begin
                    for (int k = 0; k <= lat; k++) begin
                        @(posedge clk); #1;
                        if (k == lat) begin
                            bus.done   = st | (SN'($urandom) & ~st);
                            bus.result = res;
                            last_done_cyc = cyc;
                            model_wb(st, res, cyc + 2);
                        end else begin
                            bus.done   = SN'($urandom) & ~st;
                            bus.result = rand_res();
                        end
                    end
                    @(posedge clk); #1;
                    bus.done   = '0;
                    bus.result = rand_res();
                end
            end
        end
    end

    // mode 0: accept by handshake; 1: must be accepted; 2: must be dropped.
    task automatic push_req(input logic [SN-1:0] st, input logic [RL-1:0] lk, input int mode, input bit lat_chk);
        iss_t e;
        bit   acc;
        @(posedge clk); #1;
        bus.stage_val = st;
        bus.l_k       = lk;
        if (mode == 1) chk("stage_rdy_open", bus.stage_rdy, 3'b111);
        if (mode == 2) chk("stage_rdy_full", bus.stage_rdy, 3'b000);
        acc = $onehot(st) && ((mode == 0) ? (bus.stage_rdy != '0) : (mode == 1));
        if (!acc && st != '0) m_err_req = 1;
        if (acc) begin
            if (st == 3'b100 && lk >= m_lmn) begin
                m_err_lk = 1;
            end else begin
                e.stage = st; e.lk = lk; e.exp_cyc = lat_chk ? cyc + 2 : -1;
                exp_iss.push_back(e);
            end
        end
    endtask

    task automatic idle_in();
        @(posedge clk); #1;
        bus.stage_val = '0;
        bus.l_k       = RL'($urandom);
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        do begin
            @(negedge clk); #1;
            n++;
        end while ((bus.busy || exp_wb.size() != 0 || bus.done != '0) && n < bound);
        if (n >= bound) chk("idle_wait_expired", n, -1);
        chk("issues_left", exp_iss.size(), 0);
    endtask

    task automatic wait_inits(input int target, input int bound);
        int n = 0;
        while (inits_seen < target && n < bound) begin
            @(negedge clk); #1;
            n++;
        end
        chk("init_wait", inits_seen >= target, 1);
    endtask

    task automatic clr_err();
        @(posedge clk); #1; bus.err_clr = 1'b1;
        @(posedge clk); #1; bus.err_clr = 1'b0;
        m_err_lk = 0; m_err_req = 0;
        @(negedge clk);
        chk("clr_err_tmo", bus.err_tmo, 0);
        chk("clr_err_req", bus.err_req, 0);
        chk("clr_err_lk", bus.err_lk, 0);
    endtask

    task automatic chk_regs(input string tag);
        chk({tag, "_xk"}, bus.xk, m_xk);
        chk({tag, "_yk"}, bus.yk, m_yk);
        chk({tag, "_xita"}, bus.xita, m_xita);
        chk({tag, "_lkx"}, bus.lkx, m_lkx);
        chk({tag, "_lky"}, bus.lky, m_lky);
    endtask

    task automatic chk_reset_vals();
        chk("rst_stage_rdy", bus.stage_rdy, 3'b111);
        chk("rst_init", bus.init, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_cur_lk", bus.cur_lk, 0);
        chk("rst_err_any", {bus.err_tmo, bus.err_req, bus.err_lk}, 0);
        chk("rst_regs", {bus.xk, bus.yk, bus.xita, bus.lkx, bus.lky}, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int tmo_seen;
        bus.stage_val = '0; bus.l_k = '0; bus.landmark_num = '0; bus.err_clr = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_vals();
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset_vals();

        // Single update, done 20 cycles after init
        m_lmn = 4; bus.landmark_num = m_lmn;
        lat_q.push_back(19);
        res_q.push_back({16'd5, 16'd4, 16'd3, 16'd2, 16'd1, 16'hFFFF});
        push_req(3'b100, 10'd2, 1, 1);
        idle_in();
        wait_idle(100);
        chk("s1_xk", bus.xk, 1);
        chk("s1_yk", bus.yk, 2);
        chk("s1_xita", bus.xita, 3);
        chk("s1_lkx", bus.lkx, 4);
        chk("s1_lky", bus.lky, 5);
        chk("s1_busy_fall", busy_fall_cyc, last_done_cyc + 2);

        // Predict then new landmark on consecutive cycles
        res_q.push_back({16'd9, 16'd8, 16'd3, 16'd2, 16'd1, 16'hFFFF});
        res_q.push_back({16'd9, 16'd8, 16'd3, 16'd2, 16'd1, 16'hFFFF});
        push_req(3'b001, 10'd7, 1, 1);
        push_req(3'b010, 10'd3, 1, 0);
        idle_in();
        wait_idle(100);
        chk("s2_xk", bus.xk, 1);
        chk("s2_lkx_wrap", bus.lkx, 0);
        chk("s2_lky", bus.lky, 5);

        // Fill the FIFO while the first request waits; fifth push dropped
        n = inits_seen;
        lat_q.push_back(30);
        push_req(3'b100, 10'd1, 1, 1);
        idle_in();
        wait_inits(n + 1, 20);
        push_req(3'b001, 10'd0, 1, 0);
        push_req(3'b010, 10'd5, 1, 0);
        push_req(3'b100, 10'd3, 1, 0);
        push_req(3'b001, 10'd9, 1, 0);
        push_req(3'b010, 10'd1, 2, 0);
        idle_in();
        @(negedge clk);
        chk("s3_err_req", bus.err_req, 1);
        wait_idle(400);
        chk_regs("s3");
        clr_err();

        // Update with l_k == landmark_num is skipped
        push_req(3'b100, 10'd4, 1, 0);
        idle_in();
        wait_idle(50);
        chk("s4_err_lk", bus.err_lk, 1);
        chk_regs("s4");
        clr_err();

        // Watchdog timeout, queued request issues afterwards
        push_req(3'b010, 10'd0, 1, 1);
        idle_in();
        wait_idle(50);
        lat_q.push_back(-1);
        push_req(3'b001, 10'd0, 1, 1);
        push_req(3'b010, 10'd2, 1, 0);
        idle_in();
        n = 0;
        tmo_seen = 0;
        while (!tmo_seen && n < 4 * TMO_CYC) begin
            @(negedge clk); #1;
            n++;
            if (bus.err_tmo) tmo_seen = 1;
        end
        chk("s5_err_tmo", tmo_seen, 1);
        chk("s5_tmo_cycle", cyc, last_init_cyc + TMO_CYC + 1);
        wait_idle(100);
        chk_regs("s5");
        clr_err();

        // done coincides with the terminal count
        lat_q.push_back(TMO_CYC - 1);
        push_req(3'b001, 10'd0, 1, 1);
        idle_in();
        wait_idle(4 * TMO_CYC);
        chk("s5b_err_tmo", bus.err_tmo, 0);
        chk_regs("s5b");

        // Non-one-hot request together with err_clr: set wins, nothing queued
        @(posedge clk); #1; bus.stage_val = 3'b011; bus.err_clr = 1'b1;
        @(posedge clk); #1; bus.stage_val = '0; bus.err_clr = 1'b0;
        @(negedge clk);
        chk("s6_err_req", bus.err_req, 1);
        chk("s6_busy", bus.busy, 0);
        clr_err();

        // Reset during WAIT
        n = inits_seen;
        lat_q.push_back(-1);
        push_req(3'b100, 10'd0, 1, 1);
        idle_in();
        wait_inits(n + 1, 20);
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_vals();
        exp_iss.delete(); exp_wb.delete(); lat_q.delete(); res_q.delete();
        m_xk = '0; m_yk = '0; m_xita = '0; m_lkx = '0; m_lky = '0;
        m_err_lk = 0; m_err_req = 0;
        @(posedge clk); #3 rst_n = 1'b1;
        repeat (2 * TMO_CYC) @(negedge clk);
        chk("s7_busy_after_rst", bus.busy, 0);
        chk("s7_err_after_rst", {bus.err_tmo, bus.err_req, bus.err_lk}, 0);

        // Randomized traffic
        m_lmn = 5; bus.landmark_num = m_lmn;
        for (int i = 0; i < 80; i++) begin
            logic [SN-1:0] st;
            if ($urandom_range(0, 7) == 0) begin
                st = SN'($urandom_range(3, 7));
                if ($onehot(st)) st = 3'b011;
            end else begin
                st = SN'(1 << $urandom_range(0, SN - 1));
            end
            push_req(st, RL'($urandom_range(0, 7)), 0, 0);
            repeat ($urandom_range(0, 2)) idle_in();
        end
        idle_in();
        wait_idle(3000);
        chk("rnd_err_lk", bus.err_lk, m_err_lk);
        chk("rnd_err_req", bus.err_req, m_err_req);
        chk("rnd_err_tmo", bus.err_tmo, 0);
        chk_regs("rnd");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
